// File: rtl/t05_wb_arbiter.sv
// t05_wb_arbiter: N-client single-beat Wishbone master with round-robin or
// fixed-priority arbitration and an optional ack-timeout abort.
module t05_wb_arbiter #(
  parameter int NUM_CLIENTS   = 4,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 255
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic [NUM_CLIENTS-1:0]            req_i,
  input  logic [NUM_CLIENTS-1:0]            we_i,
  input  logic [NUM_CLIENTS*(DATA_W/8)-1:0] sel_i,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]     addr_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0]     wdata_i,
  output logic [NUM_CLIENTS-1:0]            grant_o,
  output logic [NUM_CLIENTS-1:0]            done_o,
  output logic [NUM_CLIENTS-1:0]            err_o,
  output logic [DATA_W-1:0]                 rdata_o,
  output logic                              busy_o,
  output logic                              wbs_cyc_o,
  output logic                              wbs_stb_o,
  output logic                              wbs_we_o,
  output logic [DATA_W/8-1:0]               wbs_sel_o,
  output logic [ADDR_W-1:0]                 wbs_adr_o,
  output logic [DATA_W-1:0]                 wbs_dat_o,
  input  logic                              wbs_ack_i,
  input  logic [DATA_W-1:0]                 wbs_dat_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [NUM_CLIENTS-1:0] done_q, done_d;
  logic [NUM_CLIENTS-1:0] err_q, err_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [ADDR_W-1:0]      adr_q, adr_d;
  logic [DATA_W-1:0]      dat_q, dat_d;

  logic [SEL_W-1:0]  sel_arr   [NUM_CLIENTS];
  logic [ADDR_W-1:0] addr_arr  [NUM_CLIENTS];
  logic [DATA_W-1:0] wdata_arr [NUM_CLIENTS];

  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_unpack
    assign sel_arr[k]   = sel_i[k*SEL_W +: SEL_W];
    assign addr_arr[k]  = addr_i[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = wdata_i[k*DATA_W +: DATA_W];
  end

  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             win_found;

  // Scan clients starting at the round-robin pointer (or at 0 in fixed mode).
  always_comb begin : arbitrate
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (PRIORITY_MODE != 0) cand = IDX_W'(i);
      else                    cand = IDX_W'((int'(rr_q) + i) % NUM_CLIENTS);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_BUS;
          grant_d = NUM_CLIENTS'(1) << win;
          we_d    = we_i[win];
          sel_d   = sel_arr[win];
          adr_d   = addr_arr[win];
          dat_d   = wdata_arr[win];
          cyc_d   = 1'b1;
          cnt_d   = '0;
          if (PRIORITY_MODE == 0) rr_d = (win == LAST_IDX) ? '0 : win + IDX_W'(1);
        end
      end
      ST_BUS: begin
        // An ack in the final wait cycle still wins over the abort.
        if (wbs_ack_i) begin
          rdata_d = wbs_dat_i;
          cyc_d   = 1'b0;
          done_d  = grant_q;
          state_d = ST_DONE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          cyc_d   = 1'b0;
          err_d   = grant_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign grant_o   = grant_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = sel_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_t05_wb_arbiter.sv
// tb_t05_wb_arbiter: drives a round-robin and a fixed-priority arbiter with the
// same directed vectors and checks both against a transaction-level model.
module tb_t05_wb_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         nrst;
  logic [3:0]   req_i, we_i;
  logic [15:0]  sel_i;
  logic [127:0] addr_i, wdata_i;
  logic         wbs_ack_i;
  logic [31:0]  wbs_dat_i;

  logic [3:0]  grant_rr, done_rr, err_rr, sel_rr;
  logic [31:0] rdata_rr, adr_rr, dat_rr;
  logic        busy_rr, cyc_rr, stb_rr, we_rr;
  logic [3:0]  grant_fp, done_fp, err_fp, sel_fp;
  logic [31:0] rdata_fp, adr_fp, dat_fp;
  logic        busy_fp, cyc_fp, stb_fp, we_fp;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  t05_wb_arbiter #(.NUM_CLIENTS(N), .ADDR_W(32), .DATA_W(32), .PRIORITY_MODE(0), .TIMEOUT(TO)) dut_rr (
    .clk(clk), .nrst(nrst), .req_i(req_i), .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .grant_o(grant_rr), .done_o(done_rr), .err_o(err_rr), .rdata_o(rdata_rr),
    .busy_o(busy_rr), .wbs_cyc_o(cyc_rr), .wbs_stb_o(stb_rr), .wbs_we_o(we_rr), .wbs_sel_o(sel_rr),
    .wbs_adr_o(adr_rr), .wbs_dat_o(dat_rr), .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i));

  t05_wb_arbiter #(.NUM_CLIENTS(N), .ADDR_W(32), .DATA_W(32), .PRIORITY_MODE(1), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .nrst(nrst), .req_i(req_i), .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .grant_o(grant_fp), .done_o(done_fp), .err_o(err_fp), .rdata_o(rdata_fp),
    .busy_o(busy_fp), .wbs_cyc_o(cyc_fp), .wbs_stb_o(stb_fp), .wbs_we_o(we_fp), .wbs_sel_o(sel_fp),
    .wbs_adr_o(adr_fp), .wbs_dat_o(dat_fp), .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i));

  // Model state: index 0 follows the round-robin instance, 1 the fixed-priority one.
  int          m_rr, m_elapsed;
  int          own [2];
  bit          m_active, m_closing;
  logic [3:0]  e_grant [2];
  logic [3:0]  e_done  [2];
  logic [3:0]  e_err   [2];
  logic        e_we    [2];
  logic [3:0]  e_sel   [2];
  logic [31:0] e_adr   [2];
  logic [31:0] e_dat   [2];
  logic        e_cyc, e_busy;
  logic [31:0] e_rdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic setClient(input int k, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat);
    we_i[k]            = we;
    sel_i[k*4 +: 4]    = sel;
    addr_i[k*32 +: 32] = adr;
    wdata_i[k*32 +: 32] = dat;
  endtask

  // Drive one cycle of inputs and return at the sample point of the following cycle.
  task automatic applyStimulus(input logic [3:0] req, input logic ack, input logic [31:0] rdat);
    req_i     = req;
    wbs_ack_i = ack;
    wbs_dat_i = rdat;
    @(negedge clk);
  endtask

  function automatic int pickRoundRobin(input logic [3:0] r, input int start);
    for (int off = 0; off < N; off++) begin
      int c;
      c = (start + off) % N;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  function automatic int pickLowest(input logic [3:0] r);
    for (int c = 0; c < N; c++) if (r[c]) return c;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!nrst) begin
      m_rr = 0; m_elapsed = 0; m_active = 0; m_closing = 0;
      e_cyc = 0; e_busy = 0; e_rdata = '0;
      for (int m = 0; m < 2; m++) begin
        own[m] = 0; e_grant[m] = '0; e_done[m] = '0; e_err[m] = '0;
        e_we[m] = 1'b0; e_sel[m] = '0; e_adr[m] = '0; e_dat[m] = '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        e_done[m] = '0;
        e_err[m]  = '0;
      end
      if (m_closing) begin
        m_closing = 0;
        e_busy    = 0;
        for (int m = 0; m < 2; m++) e_grant[m] = '0;
      end else if (m_active) begin
        if (wbs_ack_i) begin
          e_rdata = wbs_dat_i;
          e_cyc = 0; m_active = 0; m_closing = 1;
          for (int m = 0; m < 2; m++) e_done[m] = e_grant[m];
        end else begin
          m_elapsed++;
          if (TO != 0 && m_elapsed == TO) begin
            e_cyc = 0; m_active = 0; m_closing = 1;
            for (int m = 0; m < 2; m++) e_err[m] = e_grant[m];
          end
        end
      end else if (req_i != 4'b0) begin
        own[0] = pickRoundRobin(req_i, m_rr);
        own[1] = pickLowest(req_i);
        m_rr   = (own[0] + 1) % N;
        for (int m = 0; m < 2; m++) begin
          e_grant[m] = 4'(1 << own[m]);
          e_we[m]    = we_i[own[m]];
          e_sel[m]   = sel_i[own[m]*4 +: 4];
          e_adr[m]   = addr_i[own[m]*32 +: 32];
          e_dat[m]   = wdata_i[own[m]*32 +: 32];
        end
        e_cyc = 1; e_busy = 1; m_active = 1; m_elapsed = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checkOutput("grant_rr", 32'(grant_rr), 32'(e_grant[0]));
      checkOutput("grant_fp", 32'(grant_fp), 32'(e_grant[1]));
      checkOutput("done_rr",  32'(done_rr),  32'(e_done[0]));
      checkOutput("done_fp",  32'(done_fp),  32'(e_done[1]));
      checkOutput("err_rr",   32'(err_rr),   32'(e_err[0]));
      checkOutput("err_fp",   32'(err_fp),   32'(e_err[1]));
      checkOutput("rdata_rr", rdata_rr, e_rdata);
      checkOutput("rdata_fp", rdata_fp, e_rdata);
      checkOutput("busy_rr",  32'(busy_rr), 32'(e_busy));
      checkOutput("busy_fp",  32'(busy_fp), 32'(e_busy));
      checkOutput("cyc_rr",   32'(cyc_rr),  32'(e_cyc));
      checkOutput("cyc_fp",   32'(cyc_fp),  32'(e_cyc));
      checkOutput("stb_rr",   32'(stb_rr),  32'(e_cyc));
      checkOutput("stb_fp",   32'(stb_fp),  32'(e_cyc));
      checkOutput("we_rr",    32'(we_rr),   32'(e_we[0]));
      checkOutput("we_fp",    32'(we_fp),   32'(e_we[1]));
      checkOutput("sel_rr",   32'(sel_rr),  32'(e_sel[0]));
      checkOutput("sel_fp",   32'(sel_fp),  32'(e_sel[1]));
      checkOutput("adr_rr",   adr_rr, e_adr[0]);
      checkOutput("adr_fp",   adr_fp, e_adr[1]);
      checkOutput("dat_rr",   dat_rr, e_dat[0]);
      checkOutput("dat_fp",   dat_fp, e_dat[1]);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  logic [3:0] rr_order  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] pair_order[3] = '{4'b1000, 4'b0001, 4'b1000};

  initial begin
    nrst = 1'b0; req_i = '0; we_i = '0; sel_i = '0; addr_i = '0; wdata_i = '0;
    wbs_ack_i = 1'b0; wbs_dat_i = '0;
    #7 chk_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_grant", 32'(grant_rr), 32'h0);
    checkOutput("reset_cyc",   32'(cyc_rr),   32'h0);
    checkOutput("reset_busy",  32'(busy_rr),  32'h0);
    checkOutput("reset_rdata", rdata_rr,      32'h0);
    nrst = 1'b1;

    $display("[TB] single read, client 1");
    setClient(1, 1'b0, 4'hF, 32'h3000_0010, 32'h0);
    applyStimulus(4'b0010, 1'b0, 32'h0);
    checkOutput("rd_grant", 32'(grant_rr), 32'h2);
    checkOutput("rd_cyc",   32'(cyc_rr),   32'h1);
    checkOutput("rd_adr",   adr_rr,        32'h3000_0010);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    applyStimulus(4'b0000, 1'b1, 32'hDEAD_BEEF);
    checkOutput("rd_done",  32'(done_rr), 32'h2);
    checkOutput("rd_rdata", rdata_rr,     32'hDEAD_BEEF);
    checkOutput("rd_we",    32'(we_rr),   32'h0);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    checkOutput("rd_done_once", 32'(done_rr), 32'h0);
    checkOutput("rd_idle_busy", 32'(busy_rr), 32'h0);

    $display("[TB] reset during bus cycle");
    setClient(2, 1'b0, 4'hF, 32'h3000_0020, 32'h0);
    applyStimulus(4'b0100, 1'b0, 32'h0);
    checkOutput("rst_mid_stb", 32'(stb_rr), 32'h1);
    nrst = 1'b0;
    applyStimulus(4'b0000, 1'b0, 32'h0);
    checkOutput("rst_mid_cyc",   32'(cyc_rr),   32'h0);
    checkOutput("rst_mid_grant", 32'(grant_rr), 32'h0);
    checkOutput("rst_mid_rdata", rdata_rr,      32'h0);
    nrst = 1'b1;
    applyStimulus(4'b0000, 1'b1, 32'hCAFE_F00D);
    checkOutput("late_ack_done", 32'(done_rr), 32'h0);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    checkOutput("late_ack_done2", 32'(done_rr), 32'h0);
    checkOutput("late_ack_rdata", rdata_rr,     32'h0);

    $display("[TB] round-robin contention");
    for (int k = 0; k < N; k++) setClient(k, 1'b0, 4'hF, 32'h1000_0000 + 32'(k * 4), 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b0, 32'h0);
      checkOutput("rr_grant", 32'(grant_rr), 32'(rr_order[i]));
      checkOutput("fp_grant", 32'(grant_fp), 32'h1);
      applyStimulus(4'b1111, 1'b1, 32'h100 + 32'(i));
      checkOutput("rr_done", 32'(done_rr), 32'(rr_order[i]));
      checkOutput("rr_rdata", rdata_rr, 32'h100 + 32'(i));
      applyStimulus(4'b1111, 1'b0, 32'h0);
    end

    $display("[TB] clients 0 and 3 contend");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1001, 1'b0, 32'h0);
      checkOutput("pair_rr_grant", 32'(grant_rr), 32'(pair_order[i]));
      checkOutput("pair_fp_grant", 32'(grant_fp), 32'h1);
      applyStimulus(4'b1001, 1'b1, 32'h200 + 32'(i));
      applyStimulus(4'b1001, 1'b0, 32'h0);
    end

    $display("[TB] timeout abort");
    applyStimulus(4'b0100, 1'b0, 32'h0);
    for (int i = 1; i <= TO; i++) begin
      applyStimulus(4'b0000, 1'b0, 32'h0);
      checkOutput("to_err_rr", 32'(err_rr), (i == TO) ? 32'h4 : 32'h0);
      checkOutput("to_err_fp", 32'(err_fp), (i == TO) ? 32'h4 : 32'h0);
      checkOutput("to_no_done", 32'(done_rr), 32'h0);
    end
    applyStimulus(4'b0000, 1'b0, 32'h0);
    checkOutput("to_idle_busy", 32'(busy_rr), 32'h0);
    checkOutput("to_rdata_kept", rdata_rr, 32'h202);
    applyStimulus(4'b1000, 1'b0, 32'h0);
    checkOutput("after_to_grant", 32'(grant_rr), 32'h8);
    applyStimulus(4'b0000, 1'b1, 32'h5555_AAAA);
    checkOutput("after_to_done", 32'(done_rr), 32'h8);
    applyStimulus(4'b0000, 1'b0, 32'h0);

    $display("[TB] ack on the last wait cycle");
    applyStimulus(4'b0010, 1'b0, 32'h0);
    for (int i = 1; i < TO; i++) applyStimulus(4'b0000, 1'b0, 32'h0);
    applyStimulus(4'b0000, 1'b1, 32'h0BAD_F00D);
    checkOutput("edge_done", 32'(done_rr), 32'h2);
    checkOutput("edge_err",  32'(err_rr),  32'h0);
    checkOutput("edge_rdata", rdata_rr,    32'h0BAD_F00D);
    applyStimulus(4'b0000, 1'b0, 32'h0);

    $display("[TB] write pass-through");
    setClient(0, 1'b1, 4'b0011, 32'h2000_0004, 32'h1234_5678);
    applyStimulus(4'b0001, 1'b0, 32'h0);
    checkOutput("wr_we",  32'(we_rr),  32'h1);
    checkOutput("wr_sel", 32'(sel_rr), 32'h3);
    checkOutput("wr_dat", dat_rr,      32'h1234_5678);
    checkOutput("wr_adr", adr_rr,      32'h2000_0004);
    applyStimulus(4'b0000, 1'b1, 32'hFFFF_0000);
    checkOutput("wr_done",  32'(done_rr), 32'h1);
    checkOutput("wr_rdata", rdata_rr,     32'hFFFF_0000);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    applyStimulus(4'b0000, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
